// File: rtl/ysyx_25020037_mem_arbiter_pkg.sv
// Shared encodings for the IFU/LSU memory arbiter: FSM states, master IDs, AXI response codes.
package ysyx_25020037_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_IFU_RD = 2'd1,
        ST_LSU_RD = 2'd2,
        ST_LSU_WR = 2'd3
    } state_t;

    localparam logic MST_IFU = 1'b0;
    localparam logic MST_LSU = 1'b1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/ysyx_25020037_rr_arb2.sv
// Two-way round-robin picker: on a tie the master that was not granted last wins.
// Latency: purely combinational.
// Backpressure: none; grant is one-hot or zero and only reflects current requests.
module ysyx_25020037_rr_arb2
    import ysyx_25020037_mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last == MST_LSU) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/ysyx_25020037_mem_arbiter.sv
// Shares one AXI4-Lite slave port between IFU (read-only) and LSU (read/write), one transaction at a time.
// Latency: grant registered, 1 cycle request->s_*valid; 1 idle bubble after each release.
// Backpressure: granted master's channels pass through combinationally; others see ready=0 until release.
module ysyx_25020037_mem_arbiter
    import ysyx_25020037_mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic [31:0] ifu_araddr,
    input  logic        ifu_arvalid,
    output logic        ifu_arready,
    output logic [31:0] ifu_rdata,
    output logic [1:0]  ifu_rresp,
    output logic        ifu_rvalid,
    input  logic        ifu_rready,

    input  logic [31:0] lsu_araddr,
    input  logic        lsu_arvalid,
    output logic        lsu_arready,
    output logic [31:0] lsu_rdata,
    output logic [1:0]  lsu_rresp,
    output logic        lsu_rvalid,
    input  logic        lsu_rready,
    input  logic [31:0] lsu_awaddr,
    input  logic        lsu_awvalid,
    output logic        lsu_awready,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wstrb,
    input  logic        lsu_wvalid,
    output logic        lsu_wready,
    output logic [1:0]  lsu_bresp,
    output logic        lsu_bvalid,
    input  logic        lsu_bready,

    output logic [31:0] s_araddr,
    output logic        s_arvalid,
    input  logic        s_arready,
    input  logic [31:0] s_rdata,
    input  logic [1:0]  s_rresp,
    input  logic        s_rvalid,
    output logic        s_rready,
    output logic [31:0] s_awaddr,
    output logic        s_awvalid,
    input  logic        s_awready,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    output logic        s_wvalid,
    input  logic        s_wready,
    input  logic [1:0]  s_bresp,
    input  logic        s_bvalid,
    output logic        s_bready
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t             state, state_nxt;
    logic               last, last_nxt;
    logic               err, err_nxt;
    logic               drain, drain_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [1:0]         req, gnt;

    assign req = {lsu_arvalid | lsu_awvalid, ifu_arvalid};

    ysyx_25020037_rr_arb2 u_rr (
        .req   (req),
        .last  (last),
        .grant (gnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            last  <= MST_LSU;
            err   <= 1'b0;
            drain <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
            err   <= err_nxt;
            drain <= drain_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // err latches a forced SLVERR; drain keeps s_rready/s_bready high in IDLE
    // so a slave that answers after the timeout does not hang.
    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        err_nxt   = err;
        drain_nxt = drain;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                if (s_rvalid || s_bvalid) drain_nxt = 1'b0;
                if (gnt != 2'b00) begin
                    cnt_nxt   = '0;
                    err_nxt   = 1'b0;
                    drain_nxt = 1'b0;
                    if (gnt[0])           state_nxt = ST_IFU_RD;
                    else if (lsu_arvalid) state_nxt = ST_LSU_RD;
                    else                  state_nxt = ST_LSU_WR;
                end
            end
            ST_IFU_RD, ST_LSU_RD: begin
                if ((err || s_rvalid) &&
                    ((state == ST_IFU_RD) ? ifu_rready : lsu_rready)) begin
                    state_nxt = ST_IDLE;
                    err_nxt   = 1'b0;
                    last_nxt  = (state == ST_IFU_RD) ? MST_IFU : MST_LSU;
                end else if (!err) begin
                    if (cnt == CNT_LAST && !s_rvalid) begin
                        err_nxt   = 1'b1;
                        drain_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end
            end
            ST_LSU_WR: begin
                if ((err || s_bvalid) && lsu_bready) begin
                    state_nxt = ST_IDLE;
                    err_nxt   = 1'b0;
                    last_nxt  = MST_LSU;
                end else if (!err) begin
                    if (cnt == CNT_LAST && !s_bvalid) begin
                        err_nxt   = 1'b1;
                        drain_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        ifu_arready = 1'b0;
        ifu_rdata   = '0;
        ifu_rresp   = RESP_OKAY;
        ifu_rvalid  = 1'b0;
        lsu_arready = 1'b0;
        lsu_rdata   = '0;
        lsu_rresp   = RESP_OKAY;
        lsu_rvalid  = 1'b0;
        lsu_awready = 1'b0;
        lsu_wready  = 1'b0;
        lsu_bresp   = RESP_OKAY;
        lsu_bvalid  = 1'b0;
        s_araddr    = '0;
        s_arvalid   = 1'b0;
        s_rready    = 1'b0;
        s_awaddr    = '0;
        s_awvalid   = 1'b0;
        s_wdata     = '0;
        s_wstrb     = '0;
        s_wvalid    = 1'b0;
        s_bready    = 1'b0;
        case (state)
            ST_IDLE: begin
                s_rready = drain;
                s_bready = drain;
            end
            ST_IFU_RD: begin
                s_araddr    = ifu_araddr;
                s_arvalid   = ifu_arvalid & ~err;
                ifu_arready = s_arready & ~err;
                s_rready    = err | ifu_rready;
                ifu_rvalid  = err | s_rvalid;
                ifu_rdata   = err ? 32'h0 : s_rdata;
                ifu_rresp   = err ? RESP_SLVERR : s_rresp;
            end
            ST_LSU_RD: begin
                s_araddr    = lsu_araddr;
                s_arvalid   = lsu_arvalid & ~err;
                lsu_arready = s_arready & ~err;
                s_rready    = err | lsu_rready;
                lsu_rvalid  = err | s_rvalid;
                lsu_rdata   = err ? 32'h0 : s_rdata;
                lsu_rresp   = err ? RESP_SLVERR : s_rresp;
            end
            ST_LSU_WR: begin
                s_awaddr    = lsu_awaddr;
                s_awvalid   = lsu_awvalid & ~err;
                lsu_awready = s_awready & ~err;
                s_wdata     = lsu_wdata;
                s_wstrb     = lsu_wstrb;
                s_wvalid    = lsu_wvalid & ~err;
                lsu_wready  = s_wready & ~err;
                s_bready    = err | lsu_bready;
                lsu_bvalid  = err | s_bvalid;
                lsu_bresp   = err ? RESP_SLVERR : s_bresp;
            end
            default: ;
        endcase
    end

endmodule
